// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR random-source blocks.
// Contents:
//   fsm_t      - range generator control states (IDLE, DRAW)
//   TAPS_8..16 - maximal-length Fibonacci feedback masks, bit i = state[i]
//   mask_fill  - smears the highest set bit downwards, giving the smallest
//                all-ones value >= the argument
package lfsr_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      DRAW = 1'b1
   } fsm_t;

   localparam logic [7:0]  TAPS_8  = 8'hB8;
   localparam logic [8:0]  TAPS_9  = 9'h110;
   localparam logic [9:0]  TAPS_10 = 10'h240;
   localparam logic [10:0] TAPS_11 = 11'h500;
   localparam logic [11:0] TAPS_12 = 12'hE08;
   localparam logic [12:0] TAPS_13 = 13'h1C80;
   localparam logic [13:0] TAPS_14 = 14'h3802;
   localparam logic [14:0] TAPS_15 = 15'h6000;
   localparam logic [15:0] TAPS_16 = 16'hD008;

   function automatic logic [31:0] mask_fill(input logic [31:0] x);
      logic [31:0] m;
      m = x;
      m = m | (m >> 1);
      m = m | (m >> 2);
      m = m | (m >> 4);
      m = m | (m >> 8);
      m = m | (m >> 16);
      return m;
   endfunction

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR register with seed load and zero lock-up guard.
// Ports:
//   clock  - system clock, rising edge
//   reset  - asynchronous active-low reset, loads SEED_DEFAULT
//   load   - synchronous seed load (priority over step)
//   seed   - value stored on load; 0 is replaced by 1
//   step   - advance the register by one shift
//   state  - current register contents
module lfsr_core #(
   parameter int unsigned       WIDTH        = 11,
   parameter logic [WIDTH-1:0]  TAPS         = 11'h500,
   parameter logic [WIDTH-1:0]  SEED_DEFAULT = 11'h001
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] seed,
   input  logic             step,
   output logic [WIDTH-1:0] state
);

   logic             fb;
   logic [WIDTH-1:0] seed_safe;

   assign fb        = ^(state & TAPS);
   // The all-zero state is a fixed point of the XOR feedback, so never store it.
   assign seed_safe = (seed == '0) ? WIDTH'(1) : seed;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= SEED_DEFAULT;
      end else if (load) begin
         state <= seed_safe;
      end else if (step) begin
         state <= {state[WIDTH-2:0], fb};
      end
   end

endmodule

// File: rtl/lfsr_range_gen.sv
// Bounded random value generator: LFSR plus request/valid front end that
// returns values uniformly in [0, limit) by bounded rejection sampling.
// Ports:
//   clock  - system clock, rising edge
//   reset  - asynchronous active-low reset
//   seed   - LFSR value captured on load
//   load   - synchronous seed load; aborts any draw, drops a same-cycle req
//   req    - draw request, honoured in IDLE only
//   limit  - exclusive upper bound captured with req; 0 = full range
//   busy   - high while drawing
//   valid  - one-cycle pulse when value is new
//   value  - last drawn result, held until the next valid
//   out    - current LFSR state
module lfsr_range_gen
   import lfsr_pkg::*;
#(
   parameter int unsigned      WIDTH        = 11,
   parameter logic [WIDTH-1:0] TAPS         = TAPS_11,
   parameter logic [WIDTH-1:0] SEED_DEFAULT = 11'h001,
   parameter int unsigned      FREE_RUN     = 1,
   parameter int unsigned      MAX_TRIES    = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] seed,
   input  logic             load,
   input  logic             req,
   input  logic [WIDTH-1:0] limit,
   output logic             busy,
   output logic             valid,
   output logic [WIDTH-1:0] value,
   output logic [WIDTH-1:0] out
);

   localparam int unsigned     AW       = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
   localparam logic [AW-1:0]   LAST_TRY = AW'(MAX_TRIES - 1);

   fsm_t             fsm_q, fsm_d;
   logic [WIDTH-1:0] lim_q, lim_d;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic [WIDTH-1:0] value_q, value_d;
   logic [AW-1:0]    att_q, att_d;
   logic             valid_q, valid_d;
   logic             step;
   logic [WIDTH-1:0] state;
   logic [WIDTH-1:0] cand;
   logic [WIDTH-1:0] lim_m1;

   lfsr_core #(
      .WIDTH        (WIDTH),
      .TAPS         (TAPS),
      .SEED_DEFAULT (SEED_DEFAULT)
   ) u_core (
      .clock (clock),
      .reset (reset),
      .load  (load),
      .seed  (seed),
      .step  (step),
      .state (state)
   );

   assign lim_m1 = limit - WIDTH'(1);

   always_comb begin
      fsm_d   = fsm_q;
      lim_d   = lim_q;
      mask_d  = mask_q;
      value_d = value_q;
      att_d   = att_q;
      valid_d = 1'b0;
      step    = 1'b0;
      // Candidate always comes from the pre-step state of this cycle.
      cand    = (lim_q == '0) ? state : (state & mask_q);

      unique case (fsm_q)
         IDLE: begin
            if (req) begin
               lim_d  = limit;
               mask_d = WIDTH'(mask_fill(32'(lim_m1)));
               att_d  = '0;
               fsm_d  = DRAW;
            end else begin
               step = (FREE_RUN != 0);
            end
         end
         DRAW: begin
            step = 1'b1;
            if ((lim_q == '0) || (cand < lim_q)) begin
               value_d = cand;
               valid_d = 1'b1;
               fsm_d   = IDLE;
            end else if (att_q == LAST_TRY) begin
               // mask < 2*limit, so one subtraction always lands in range.
               value_d = cand - lim_q;
               valid_d = 1'b1;
               fsm_d   = IDLE;
            end else begin
               att_d = att_q + AW'(1);
            end
         end
         default: fsm_d = IDLE;
      endcase

      if (load) begin
         fsm_d   = IDLE;
         value_d = value_q;
         valid_d = 1'b0;
         att_d   = '0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         fsm_q   <= IDLE;
         lim_q   <= '0;
         mask_q  <= '0;
         value_q <= '0;
         att_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         fsm_q   <= fsm_d;
         lim_q   <= lim_d;
         mask_q  <= mask_d;
         value_q <= value_d;
         att_q   <= att_d;
         valid_q <= valid_d;
      end
   end

   assign busy  = (fsm_q == DRAW);
   assign valid = valid_q;
   assign value = value_q;
   assign out   = state;

endmodule

// File: tb/tb_lfsr_range_gen.sv
module tb_lfsr_range_gen;

   localparam int unsigned W = 11;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   int unsigned cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   logic         rst_a, load_a, req_a, busy_a, valid_a;
   logic [W-1:0] seed_a, limit_a, value_a, out_a;
   logic         rst_b, load_b, req_b, busy_b, valid_b;
   logic [W-1:0] seed_b, limit_b, value_b, out_b;

   lfsr_range_gen #(.FREE_RUN(0)) dut_a (
      .clock(clock), .reset(rst_a), .seed(seed_a), .load(load_a), .req(req_a),
      .limit(limit_a), .busy(busy_a), .valid(valid_a), .value(value_a), .out(out_a)
   );

   lfsr_range_gen #(.FREE_RUN(1), .MAX_TRIES(1)) dut_b (
      .clock(clock), .reset(rst_b), .seed(seed_b), .load(load_b), .req(req_b),
      .limit(limit_b), .busy(busy_b), .valid(valid_b), .value(value_b), .out(out_b)
   );

   typedef struct {
      logic [W-1:0] val;
      int unsigned  due;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];
   int   n_assert = 0;
   int   n_fail   = 0;
   logic [W-1:0] model_a;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: next state = shift left, new bit = parity of tapped bits.
   function automatic logic [W-1:0] lfsr_next(input logic [W-1:0] s);
      int p;
      p = $countones(s & 11'h500);
      return {s[W-2:0], p[0]};
   endfunction

   // Reference draw: rejection sampling on the smallest power-of-two range
   // covering limit, with wrap-by-subtraction after the last allowed try.
   task automatic model_draw(input logic [W-1:0] s_in, input logic [W-1:0] lim,
                             input int unsigned maxt, output logic [W-1:0] val,
                             output logic [W-1:0] s_out, output int unsigned att);
      logic [W-1:0] s;
      int unsigned  m, c;
      bit           done;
      s = s_in;
      val = '0;
      att = 0;
      if (lim == 0) begin
         val = s;
         att = 1;
         s = lfsr_next(s);
      end else begin
         m = 0;
         while (m < int'(lim) - 1) m = m * 2 + 1;
         done = 0;
         for (int unsigned a = 0; a < maxt && !done; a++) begin
            c = int'(s) & m;
            s = lfsr_next(s);
            att = a + 1;
            if (c < lim) begin
               val = W'(c); done = 1;
            end else if (a == maxt - 1) begin
               val = W'(c - lim); done = 1;
            end
         end
      end
      s_out = s;
   endtask

   // Monitors: pop one expectation per valid pulse, check value and arrival cycle.
   always @(negedge clock) begin
      exp_t e;
      if (valid_a) begin
         check("a_busy_with_valid", busy_a, 0);
         if (q_a.size() == 0) begin
            n_assert++; n_fail++;
            $display("FAIL a_unexpected_valid: got value %0h, expected no valid", value_a);
         end else begin
            e = q_a.pop_front();
            check("a_value", value_a, e.val);
            check("a_latency", cyc, e.due);
         end
      end else if (q_a.size() > 0 && cyc > q_a[0].due) begin
         n_assert++; n_fail++;
         $display("FAIL a_timeout: got no valid by cycle %0d, expected at %0d", cyc, q_a[0].due);
         void'(q_a.pop_front());
      end
   end

   always @(negedge clock) begin
      exp_t e;
      if (valid_b) begin
         check("b_busy_with_valid", busy_b, 0);
         if (q_b.size() == 0) begin
            n_assert++; n_fail++;
            $display("FAIL b_unexpected_valid: got value %0h, expected no valid", value_b);
         end else begin
            e = q_b.pop_front();
            check("b_value", value_b, e.val);
            check("b_latency", cyc, e.due);
         end
      end else if (q_b.size() > 0 && cyc > q_b[0].due) begin
         n_assert++; n_fail++;
         $display("FAIL b_timeout: got no valid by cycle %0d, expected at %0d", cyc, q_b[0].due);
         void'(q_b.pop_front());
      end
   end

   task automatic load_a_t(input logic [W-1:0] s);
      seed_a = s; load_a = 1;
      @(posedge clock); #1;
      load_a = 0;
      model_a = (s == 0) ? W'(1) : s;
   endtask

   task automatic draw_a_t(input logic [W-1:0] lim);
      logic [W-1:0] v, s_after;
      int unsigned  att, nbusy;
      exp_t         e;
      model_draw(model_a, lim, 8, v, s_after, att);
      e.val = v;
      e.due = cyc + 1 + att;
      q_a.push_back(e);
      req_a = 1; limit_a = lim;
      @(posedge clock); #1;
      req_a = 0; limit_a = W'($urandom);
      nbusy = 0;
      for (int unsigned i = 0; i <= att; i++) begin
         @(negedge clock);
         if (busy_a) nbusy++;
         @(posedge clock); #1;
      end
      model_a = s_after;
      check("a_busy_cycles", nbusy, att);
      check("a_out_after_draw", out_a, model_a);
   endtask

   initial begin
      exp_t         e;
      logic [W-1:0] mb, lim;
      int unsigned  zeros, early, diffs;

      rst_a = 0; load_a = 0; req_a = 0; seed_a = '0; limit_a = '0;
      rst_b = 0; load_b = 0; req_b = 0; seed_b = '0; limit_b = '0;
      repeat (3) @(posedge clock);
      #1;
      check("a_reset_out", out_a, 11'h001);
      check("a_reset_busy", busy_a, 0);
      check("a_reset_valid", valid_a, 0);
      check("a_reset_value", value_a, 0);
      check("b_reset_out", out_b, 11'h001);
      rst_a = 1; rst_b = 1;
      model_a = 11'h001;
      @(posedge clock); #1;

      // Idle without free-run holds the state; a limit-0 draw steps once.
      load_a_t(11'h555);
      repeat (5) @(posedge clock);
      #1;
      check("a_idle_hold", out_a, 11'h555);
      draw_a_t(0);
      check("a_step_from_555", out_a, 11'h2AA);

      // One rejection then accept (value 10), small and large limits.
      load_a_t(11'h555);
      draw_a_t(20);
      load_a_t(11'h555);
      draw_a_t(1);
      load_a_t(11'h555);
      draw_a_t(1000);

      // Reset asserted during the first draw attempt.
      load_a_t(11'h555);
      req_a = 1; limit_a = 20;
      @(posedge clock); #1;
      req_a = 0;
      rst_a = 0;
      #1;
      check("a_rst_mid_busy", busy_a, 0);
      check("a_rst_mid_valid", valid_a, 0);
      check("a_rst_mid_out", out_a, 11'h001);
      check("a_rst_mid_value", value_a, 0);
      repeat (3) @(posedge clock);
      #1;
      rst_a = 1;
      model_a = 11'h001;
      @(posedge clock); #1;

      // load and req together: load wins, no draw.
      seed_a = 11'h123; load_a = 1; req_a = 1; limit_a = 5;
      @(posedge clock); #1;
      load_a = 0; req_a = 0;
      model_a = 11'h123;
      check("a_loadreq_busy", busy_a, 0);
      @(negedge clock);
      check("a_loadreq_busy2", busy_a, 0);
      check("a_loadreq_out", out_a, 11'h123);
      @(posedge clock); #1;

      // Randomised draws with occasional reseeding.
      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(0, 9) == 0) begin
            load_a_t(($urandom_range(0, 3) == 0) ? W'(0) : W'($urandom));
            check("a_rand_load_out", out_a, model_a);
         end else begin
            case ($urandom_range(0, 4))
               0: lim = 0;
               1: lim = 1;
               2: lim = W'($urandom_range(2, 16));
               3: lim = W'($urandom_range(17, 2047));
               default: lim = W'((1 << $urandom_range(1, 10)) + $urandom_range(0, 1));
            endcase
            draw_a_t(lim);
         end
         repeat ($urandom_range(0, 2)) @(posedge clock);
         #1;
      end

      // Single-try fallback: 21 rejected, returns 21-20.
      seed_b = 11'h555; load_b = 1;
      @(posedge clock); #1;
      load_b = 0;
      e.val = 1;
      e.due = cyc + 2;
      q_b.push_back(e);
      req_b = 1; limit_b = 20;
      @(posedge clock); #1;
      req_b = 0;
      repeat (3) @(posedge clock);
      #1;

      // Zero seed becomes 1, then the full 2047-step period.
      seed_b = '0; load_b = 1;
      @(posedge clock); #1;
      load_b = 0;
      @(negedge clock);
      check("b_zero_guard", out_b, 1);
      mb = 1; zeros = 0; early = 0; diffs = 0;
      for (int k = 1; k <= 2047; k++) begin
         @(posedge clock); #1;
         mb = lfsr_next(mb);
         if (out_b == 0) zeros++;
         if (out_b != mb) diffs++;
         if (k < 2047 && out_b == 1) early++;
      end
      check("b_period_end", out_b, 1);
      check("b_never_zero", zeros, 0);
      check("b_no_early_return", early, 0);
      check("b_sequence", diffs, 0);

      repeat (12) @(posedge clock);
      #1;
      check("a_queue_drained", q_a.size(), 0);
      check("b_queue_drained", q_b.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
